// File: rtl/fifo_v2.sv
// Synchronous FIFO with optional fall-through bypass, threshold flags and
// sticky overflow/underflow indicators.
module fifo_v2 #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
   parameter int unsigned ALM_EMPTY_TH = 1,
   localparam int unsigned ADDR_W      = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [CNT_W-1:0]      usage_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wptr, rptr;
   logic [CNT_W-1:0]      count;
   logic                  overflow_q, underflow_q;
   logic                  cnt_zero, bypass, pass_thru, wr_en, rd_en;

   // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      cnt_zero       = (count == '0);
      full_o         = (count == CNT_W'(DEPTH));
      bypass         = FALL_THROUGH && cnt_zero && push_i;
      empty_o        = cnt_zero && !bypass;
      pass_thru      = bypass && pop_i;
      wr_en          = push_i && !full_o && !pass_thru;
      rd_en          = pop_i && !cnt_zero;
      data_o         = bypass ? data_i : mem[rptr];
      almost_full_o  = (count >= CNT_W'(ALM_FULL_TH));
      almost_empty_o = (count <= CNT_W'(ALM_EMPTY_TH));
      usage_o        = count;
      overflow_o     = overflow_q;
      underflow_o    = underflow_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && !flush_i) begin
         mem[wptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flush_i) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_en) wptr <= ptr_inc(wptr);
         if (rd_en) rptr <= ptr_inc(rptr);
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (rd_en && !wr_en) count <= count - 1'b1;
         if (push_i && full_o)  overflow_q  <= 1'b1;
         if (pop_i && empty_o)  underflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_v2.sv
// Directed and random checks of fifo_v2 (DEPTH=5) in registered and
// fall-through configurations against a queue scoreboard.
module tb_fifo_v2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, push, pop;
   logic [31:0] din, dout;
   logic        full, empty, af, ae, ovf, unf;
   logic [2:0]  usage;

   logic        f_flush, f_push, f_pop;
   logic [31:0] f_din, f_dout;
   logic        f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [2:0]  f_usage;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_q[$];
   bit          m_ovf, m_unf;

   always #5 clk = ~clk;

   fifo_v2 #(.DATA_WIDTH(32), .DEPTH(5), .FALL_THROUGH(1'b0),
             .ALM_FULL_TH(4), .ALM_EMPTY_TH(1)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .data_i(din),
      .push_i(push), .data_o(dout), .pop_i(pop), .full_o(full),
      .empty_o(empty), .almost_full_o(af), .almost_empty_o(ae),
      .usage_o(usage), .overflow_o(ovf), .underflow_o(unf));

   fifo_v2 #(.DATA_WIDTH(32), .DEPTH(5), .FALL_THROUGH(1'b1),
             .ALM_FULL_TH(4), .ALM_EMPTY_TH(1)) u_ft (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(f_flush), .data_i(f_din),
      .push_i(f_push), .data_o(f_dout), .pop_i(f_pop), .full_o(f_full),
      .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae),
      .usage_o(f_usage), .overflow_o(f_ovf), .underflow_o(f_unf));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      int unsigned sz;
      sz = m_q.size();
      check("usage", usage, sz);
      check("full", full, sz == 5);
      check("empty", empty, sz == 0);
      check("almost_full", af, sz >= 4);
      check("almost_empty", ae, sz <= 1);
      check("overflow", ovf, m_ovf);
      check("underflow", unf, m_unf);
      check("wptr_range", u_dut.wptr <= 3'd4, 1'b1);
      check("rptr_range", u_dut.rptr <= 3'd4, 1'b1);
      if (sz != 0) check("head", dout, m_q[0]);
   endtask

   // One clock of the registered-mode instance; the scoreboard is updated at the edge.
   task automatic step(input bit p_push, input bit p_pop, input bit p_flush, input logic [31:0] d);
      int unsigned sz;
      @(negedge clk);
      push = p_push; pop = p_pop; flush = p_flush; din = d;
      #1;
      sz = m_q.size();
      if (!p_flush && p_pop && sz != 0) check("pop_data", dout, m_q[0]);
      @(posedge clk);
      if (p_flush) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (p_push && sz == 5) m_ovf = 1'b1;
         if (p_pop && sz == 0)  m_unf = 1'b1;
         if (p_pop && sz != 0)  void'(m_q.pop_front());
         if (p_push && sz != 5) m_q.push_back(d);
      end
      #1;
      check_state();
   endtask

   task automatic ft_step(input bit p_push, input bit p_pop, input bit p_flush, input logic [31:0] d,
                          input logic [31:0] exp_now, input bit exp_empty_now,
                          input logic [2:0] exp_usage, input bit exp_empty_after,
                          input bit chk_after, input logic [31:0] exp_after);
      @(negedge clk);
      f_push = p_push; f_pop = p_pop; f_flush = p_flush; f_din = d;
      #1;
      check("ft_data_now", f_dout, exp_now);
      check("ft_empty_now", f_empty, exp_empty_now);
      @(posedge clk);
      #1;
      f_push = 1'b0; f_pop = 1'b0; f_flush = 1'b0; f_din = '0;
      #1;
      check("ft_usage", f_usage, exp_usage);
      check("ft_empty", f_empty, exp_empty_after);
      if (chk_after) check("ft_data_after", f_dout, exp_after);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
      f_flush = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_din = '0;
      m_ovf = 1'b0; m_unf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_usage", usage, 0);
      check("rst_ae", ae, 1'b1);
      check("rst_af", af, 1'b0);
      check("rst_data", dout, 0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_unf", unf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // fill to full, overflow attempt, drain in order
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'hA + i);
      step(1'b1, 1'b0, 1'b0, 32'hF);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0);

      // full with simultaneous push and pop
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + i);
      step(1'b1, 1'b1, 1'b0, 32'hF0);
      step(1'b0, 1'b1, 1'b0, '0);

      // flush with 3 entries and a concurrent push, then underflow
      step(1'b1, 1'b0, 1'b1, 32'h77);
      step(1'b0, 1'b1, 1'b0, '0);

      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, 1'b0, $urandom);
      step(1'b0, 1'b0, 1'b1, '0);

      // asynchronous reset mid-fill
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h200 + i);
      @(negedge clk);
      push = 1'b0; pop = 1'b0; flush = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_empty", empty, 1'b1);
      check("mid_rst_full", full, 1'b0);
      check("mid_rst_usage", usage, 0);
      check("mid_rst_ae", ae, 1'b1);
      check("mid_rst_af", af, 1'b0);
      check("mid_rst_data", dout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, 32'h300);
      step(1'b0, 1'b1, 1'b0, '0);

      // fall-through instance
      ft_step(1'b1, 1'b1, 1'b0, 32'h1234, 32'h1234, 1'b0, 3'd0, 1'b1, 1'b0, '0);
      check("ft_no_underflow", f_unf, 1'b0);
      ft_step(1'b1, 1'b0, 1'b0, 32'h5678, 32'h5678, 1'b0, 3'd1, 1'b0, 1'b1, 32'h5678);
      ft_step(1'b1, 1'b1, 1'b0, 32'h9ABC, 32'h5678, 1'b0, 3'd1, 1'b0, 1'b1, 32'h9ABC);
      ft_step(1'b0, 1'b1, 1'b0, '0, 32'h9ABC, 1'b0, 3'd0, 1'b1, 1'b0, '0);
      ft_step(1'b1, 1'b0, 1'b1, 32'hBEEF, 32'hBEEF, 1'b0, 3'd0, 1'b1, 1'b0, '0);
      ft_step(1'b0, 1'b1, 1'b0, '0, 32'h5678, 1'b1, 3'd0, 1'b1, 1'b0, '0);
      check("ft_underflow", f_unf, 1'b1);
      check("ft_overflow", f_ovf, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
